alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one 4-bit ALU between NUM_REQ requesters.
//  Accepts one operation at a time, drives the ALU operand bus, waits for completion,
//  and returns result+flags tagged with the requester id. Timeout guards a hung ALU.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..8)
//  ID_W     2   width of rsp_id; must satisfy 2**ID_W >= NUM_REQ
//  TIMEOUT  15  max cycles spent in WAIT before an error response (1..255)
// PORTS
//  clk           in   1          single clock, rising edge
//  rst_n         in   1          reset, synchronous, active-low
//  req_valid     in   NUM_REQ    per-requester operation valid
//  req_ready     out  NUM_REQ    one-hot accept; at most one bit high per cycle
//  req_a         in   4*NUM_REQ  operand A, requester i at [4i+3:4i]
//  req_b         in   4*NUM_REQ  operand B, same packing
//  req_op        in   2*NUM_REQ  op (00 add, 01 sub, 10 and, 11 or), requester i at [2i+1:2i]
//  alu_start     out  1          one-cycle pulse launching the ALU operation
//  alu_a/alu_b   out  4 each     registered operands, held stable ISSUE..end of WAIT
//  alu_op        out  2          registered op, held stable with operands
//  alu_done      in   1          ALU completion strobe; alu_result/flags valid this cycle
//  alu_result    in   4          ALU result
//  alu_flags     in   3          {carry, zero, overflow}
//  rsp_valid     out  1          response valid
//  rsp_ready     in   1          response consumer ready
//  rsp_id        out  ID_W       granted requester index
//  rsp_result    out  4          captured result (0 on error)
//  rsp_flags     out  3          captured {carry,zero,overflow} (0 on error)
//  rsp_err       out  1          1 = ALU timeout
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer 0, timeout counter 0, regardless of state.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   IDLE: if any req_valid, grant lowest index >= rr_ptr (circular); assert req_ready[g]
//         combinationally same cycle; capture A/B/op and id; go ISSUE. No valid: stay.
//   ISSUE: alu_start=1 for exactly this cycle; clear timeout ctr; go WAIT.
//   WAIT: alu_done=1 -> capture result/flags, rsp_err=0, go RESP.
//         ctr reaches TIMEOUT with no done -> result/flags=0, rsp_err=1, go RESP.
//         alu_done in the same cycle as the timeout: done wins (no error).
//   RESP: rsp_valid=1, outputs stable until rsp_valid&&rsp_ready; then rr_ptr=(g+1)
//         mod NUM_REQ, go IDLE. Earliest next grant: cycle after handshake.
//  Latency: grant -> alu_start 1 cycle; alu_done -> rsp_valid 1 cycle.
//  alu_done outside WAIT is ignored. req_valid may drop without grant (no loss).
//  Throughput: one op outstanding; min 4 cycles per op with 1-cycle ALU.
//  rr_ptr wraps NUM_REQ-1 -> 0; unused ID_W codes never issued.
// CONFIGURATION
//  ARB_STATS_EN defined: adds output stat_grants [8*NUM_REQ] - per-requester 8-bit
//   grant counters, +1 on each IDLE grant, saturate at 255, cleared by reset; plus
//   output stat_timeouts [8], +1 per error response, saturating.
//  ARB_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 single req0 A=F B=1 op=00, ALU done after 3 cyc -> rsp_id=0 result=0 flags=110 err=0
//  2 all four valid continuously -> grant order 0,1,2,3,0; no requester granted twice in a row
//  3 alu_done never asserted, TIMEOUT=15 -> rsp_valid 16 cycles after start, err=1, result=0
//  4 rsp_ready low 5 cycles in RESP -> rsp fields stable, no new req_ready until handshake
//  5 rst_n low during WAIT -> next cycle all outputs 0, rr_ptr 0; stray alu_done ignored
//  6 ARB_STATS_EN: 300 grants to req1 -> stat_grants[15:8]=255

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin sequencer sharing one 4-bit ALU between NUM_REQ requesters, with a WAIT timeout.
// Optional per-requester grant / timeout statistics are compiled in when ARB_STATS_EN is defined.
//
// state | meaning
// IDLE  | look for a valid requester, grant round-robin from rr_ptr, latch operands
// ISSUE | pulse alu_start, clear timeout counter
// WAIT  | wait for alu_done or timeout, capture result/flags/err
// RESP  | hold response until rsp_ready, then advance rr_ptr
module alu_share_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int TIMEOUT = 15
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [4*NUM_REQ-1:0]   req_a,
   input  logic [4*NUM_REQ-1:0]   req_b,
   input  logic [2*NUM_REQ-1:0]   req_op,
   output logic                   alu_start,
   output logic [3:0]             alu_a,
   output logic [3:0]             alu_b,
   output logic [1:0]             alu_op,
   input  logic                   alu_done,
   input  logic [3:0]             alu_result,
   input  logic [2:0]             alu_flags,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic [3:0]             rsp_result,
   output logic [2:0]             rsp_flags,
   output logic                   rsp_err
`ifdef ARB_STATS_EN
   ,
   output logic [8*NUM_REQ-1:0]   stat_grants,
   output logic [7:0]             stat_timeouts
`endif
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   grant_idx;
   logic              grant_any;
   logic [7:0]        tmr;
   logic              tmo;
   logic [3:0]        sel_a;
   logic [3:0]        sel_b;
   logic [1:0]        sel_op;

   // Scan from the highest offset down so the lowest circular offset from rr_ptr wins.
   always_comb begin
      int               idx;
      logic [NUM_REQ-1:0] vld_rot;
      idx       = 0;
      vld_rot   = '0;
      grant_any = 1'b0;
      grant_idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ)
            idx = idx - NUM_REQ;
         vld_rot = req_valid >> idx;
         if (vld_rot[0]) begin
            grant_any = 1'b1;
            grant_idx = ID_W'(idx);
         end
      end
   end

   assign sel_a  = 4'(req_a  >> (4 * int'(grant_idx)));
   assign sel_b  = 4'(req_b  >> (4 * int'(grant_idx)));
   assign sel_op = 2'(req_op >> (2 * int'(grant_idx)));
   assign tmo    = (tmr == 8'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_any) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (alu_done || tmo) state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // req_ready is gated by rst_n so the accept strobe is quiet while reset is held.
   always_comb begin
      req_ready = '0;
      alu_start = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         IDLE:    if (grant_any && rst_n) req_ready = NUM_REQ'(1) << grant_idx;
         ISSUE:   alu_start = 1'b1;
         RESP:    rsp_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr     <= '0;
         tmr        <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_op     <= '0;
         rsp_id     <= '0;
         rsp_result <= '0;
         rsp_flags  <= '0;
         rsp_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_any) begin
                  alu_a  <= sel_a;
                  alu_b  <= sel_b;
                  alu_op <= sel_op;
                  rsp_id <= grant_idx;
               end
            end
            ISSUE: tmr <= '0;
            WAIT: begin
               // done has priority over a timeout landing in the same cycle
               if (alu_done) begin
                  rsp_result <= alu_result;
                  rsp_flags  <= alu_flags;
                  rsp_err    <= 1'b0;
               end else if (tmo) begin
                  rsp_result <= '0;
                  rsp_flags  <= '0;
                  rsp_err    <= 1'b1;
               end else begin
                  tmr <= tmr + 8'd1;
               end
            end
            RESP: begin
               if (rsp_ready)
                  rr_ptr <= (rsp_id == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id + 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_grants   <= '0;
         stat_timeouts <= '0;
      end else begin
         if (state == IDLE && grant_any) begin
            for (int k = 0; k < NUM_REQ; k++) begin
               if (grant_idx == ID_W'(k) && stat_grants[8*k +: 8] != 8'hFF)
                  stat_grants[8*k +: 8] <= stat_grants[8*k +: 8] + 8'd1;
            end
         end
         if (state == WAIT && !alu_done && tmo && stat_timeouts != 8'hFF)
            stat_timeouts <= stat_timeouts + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: vector table for single ops plus round-robin,
// timeout, back-pressure and reset-during-WAIT sequences; stats checks under ARB_STATS_EN.
module tb_alu_share_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic [7:0]  req_op;
   logic        alu_start;
   logic [3:0]  alu_a;
   logic [3:0]  alu_b;
   logic [1:0]  alu_op;
   logic        alu_done;
   logic [3:0]  alu_result;
   logic [2:0]  alu_flags;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_id;
   logic [3:0]  rsp_result;
   logic [2:0]  rsp_flags;
   logic        rsp_err;
`ifdef ARB_STATS_EN
   logic [31:0] stat_grants;
   logic [7:0]  stat_timeouts;
`endif

   int n_checks = 0;
   int n_err    = 0;

   alu_share_arbiter #(.NUM_REQ(4), .ID_W(2), .TIMEOUT(15)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_op     (req_op),
      .alu_start  (alu_start),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_done   (alu_done),
      .alu_result (alu_result),
      .alu_flags  (alu_flags),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_flags  (rsp_flags),
      .rsp_err    (rsp_err)
`ifdef ARB_STATS_EN
      ,
      .stat_grants   (stat_grants),
      .stat_timeouts (stat_timeouts)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int         idx;
      logic [3:0] a;
      logic [3:0] b;
      logic [1:0] op;
      int         lat;
      logic [3:0] res;
      logic [2:0] fl;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // External ALU behaviour: returns {carry, zero, overflow, result}.
   function automatic logic [6:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                            input logic [1:0] op);
      logic [4:0] s;
      logic [3:0] r;
      logic       c;
      logic       v;
      s = '0; c = 1'b0; v = 1'b0;
      case (op)
         2'b00: begin
            s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4];
            v = (a[3] == b[3]) && (r[3] != a[3]);
         end
         2'b01: begin
            s = {1'b0, a} - {1'b0, b}; r = s[3:0]; c = s[4];
            v = (a[3] != b[3]) && (r[3] != a[3]);
         end
         2'b10:   r = a & b;
         default: r = a | b;
      endcase
      return {c, (r == 4'h0), v, r};
   endfunction

   task automatic do_reset();
      rst_n = 1'b0; req_valid = '0; alu_done = 1'b0; rsp_ready = 1'b0;
      alu_result = '0; alu_flags = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_grant(input logic [3:0] exp_oh, input string name);
      int n;
      n = 0;
      #1;
      while (req_ready == 4'b0 && n < 20) begin
         @(negedge clk); #1;
         n++;
      end
      check(name, 32'(req_ready), 32'(exp_oh));
   endtask

   task automatic drive_alu_done();
      logic [6:0] m;
      m = alu_model(alu_a, alu_b, alu_op);
      alu_done = 1'b1; alu_result = m[3:0]; alu_flags = m[6:4];
   endtask

   task automatic set_req(input int idx, input logic [3:0] a, input logic [3:0] b,
                          input logic [1:0] op);
      req_a[4*idx +: 4]  = a;
      req_b[4*idx +: 4]  = b;
      req_op[2*idx +: 2] = op;
   endtask

   task automatic run_vec(input vec_t v, input int n);
      logic [3:0] oh;
      oh = 4'b0001 << v.idx;
      set_req(v.idx, v.a, v.b, v.op);
      req_valid = oh;
      wait_grant(oh, $sformatf("v%0d_grant", n));
      @(negedge clk);
      req_valid = '0;
      check($sformatf("v%0d_start", n), 32'(alu_start), 32'd1);
      check($sformatf("v%0d_operands", n), {22'd0, alu_a, alu_b, alu_op}, {22'd0, v.a, v.b, v.op});
      repeat (v.lat) @(negedge clk);
      check($sformatf("v%0d_start_pulse", n), 32'(alu_start), 32'd0);
      drive_alu_done();
      @(negedge clk);
      alu_done = 1'b0;
      check($sformatf("v%0d_rsp_valid", n), 32'(rsp_valid), 32'd1);
      check($sformatf("v%0d_rsp", n), {22'd0, rsp_id, rsp_result, rsp_flags, rsp_err},
            {22'd0, 2'(v.idx), v.res, v.fl, 1'b0});
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check($sformatf("v%0d_rsp_clear", n), 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      logic [9:0] held;

      vecs[0] = '{0, 4'hF, 4'h1, 2'b00, 3, 4'h0, 3'b110};
      vecs[1] = '{1, 4'h3, 4'h5, 2'b01, 1, 4'hE, 3'b100};
      vecs[2] = '{2, 4'hC, 4'hA, 2'b10, 2, 4'h8, 3'b000};
      vecs[3] = '{3, 4'h5, 4'h2, 2'b11, 1, 4'h7, 3'b000};
      vecs[4] = '{1, 4'h7, 4'h1, 2'b00, 4, 4'h8, 3'b001};
      vecs[5] = '{2, 4'hA, 4'h5, 2'b10, 1, 4'h0, 3'b010};

      req_a = '0; req_b = '0; req_op = '0;
      do_reset();
      #1;
      check("reset_ctrl", {29'd0, alu_start, rsp_valid, rsp_err}, 32'd0);
      check("reset_req_ready", 32'(req_ready), 32'd0);
      check("reset_data", {19'd0, alu_a, alu_b, alu_op, rsp_result}, 32'd0);
      check("reset_rsp", {27'd0, rsp_id, rsp_flags}, 32'd0);

      foreach (vecs[i]) run_vec(vecs[i], i);

      // all four requesters valid continuously, 1-cycle ALU
      do_reset();
      for (int i = 0; i < 4; i++) set_req(i, 4'(i + 1), 4'h1, 2'b00);
      rsp_ready = 1'b1;
      req_valid = 4'hF;
      for (int n = 0; n < 5; n++) begin
         wait_grant(4'b0001 << (n % 4), $sformatf("rr_grant%0d", n));
         @(negedge clk);
         @(negedge clk);
         drive_alu_done();
         @(negedge clk);
         alu_done = 1'b0;
         check($sformatf("rr_rsp_id%0d", n), 32'(rsp_id), 32'(n % 4));
         check($sformatf("rr_rsp_res%0d", n), 32'(rsp_result), 32'((n % 4) + 2));
         @(negedge clk);
      end
      req_valid = '0;
      rsp_ready = 1'b0;

      // timeout: alu_done never arrives
      set_req(0, 4'h3, 4'h4, 2'b00);
      req_valid = 4'b0001;
      wait_grant(4'b0001, "tmo_grant");
      @(negedge clk);
      req_valid = '0;
      k = 0;
      while (!rsp_valid && k < 40) begin
         @(negedge clk);
         k++;
      end
      check("tmo_latency", 32'(k), 32'd16);
      check("tmo_rsp", {22'd0, rsp_id, rsp_result, rsp_flags, rsp_err}, {22'd0, 2'd0, 4'h0, 3'b000, 1'b1});
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
`ifdef ARB_STATS_EN
      check("stat_timeouts_one", 32'(stat_timeouts), 32'd1);
`endif

      // done on the final WAIT cycle wins over the timeout
      set_req(2, 4'h6, 4'h3, 2'b01);
      req_valid = 4'b0100;
      wait_grant(4'b0100, "edge_grant");
      @(negedge clk);
      req_valid = '0;
      repeat (15) @(negedge clk);
      drive_alu_done();
      @(negedge clk);
      alu_done = 1'b0;
      check("edge_rsp_valid", 32'(rsp_valid), 32'd1);
      check("edge_rsp", {22'd0, rsp_id, rsp_result, rsp_flags, rsp_err}, {22'd0, 2'd2, 4'h3, 3'b000, 1'b0});
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;

      // back-pressure: hold RESP five cycles with everyone else requesting
      set_req(3, 4'h9, 4'h9, 2'b00);
      req_valid = 4'b1000;
      wait_grant(4'b1000, "bp_grant");
      @(negedge clk);
      req_valid = '0;
      repeat (2) @(negedge clk);
      drive_alu_done();
      @(negedge clk);
      alu_done = 1'b0;
      req_valid = 4'hF;
      #1;
      held = {rsp_id, rsp_result, rsp_flags, rsp_err};
      check("bp_rsp", 32'(held), {22'd0, 2'd3, 4'h2, 3'b101, 1'b0});
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         check($sformatf("bp_hold%0d", i), {17'd0, rsp_valid, req_ready, rsp_id, rsp_result, rsp_flags, rsp_err},
               {17'd0, 1'b1, 4'b0000, held});
      end
      rsp_ready = 1'b1;
      @(negedge clk); #1;
      rsp_ready = 1'b0;
      check("bp_next_grant", 32'(req_ready), 32'b0001);
      req_valid = '0;
      @(negedge clk); #1;
      check("drop_no_grant", {30'd0, alu_start, rsp_valid}, 32'd0);

      // reset while in WAIT, with a stray alu_done around it
      set_req(1, 4'h1, 4'h2, 2'b11);
      req_valid = 4'b0010;
      wait_grant(4'b0010, "rst_grant");
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      rst_n = 1'b0;
      alu_done = 1'b1; alu_result = 4'hF; alu_flags = 3'b111;
      req_valid = 4'hF;
      @(negedge clk); #1;
      check("rstw_ctrl", {27'd0, req_ready, alu_start}, 32'd0);
      check("rstw_rsp", {22'd0, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err}, 32'd0);
      check("rstw_alu", {22'd0, alu_a, alu_b, alu_op}, 32'd0);
      rst_n = 1'b1;
      req_valid = '0;
      repeat (2) begin
         @(negedge clk); #1;
         check("stray_done", {30'd0, alu_start, rsp_valid}, 32'd0);
      end
      alu_done = 1'b0;
      req_valid = 4'hF;
      wait_grant(4'b0001, "rstw_rr_ptr0");
      req_valid = '0;

`ifdef ARB_STATS_EN
      check("stat_timeouts_reset", 32'(stat_timeouts), 32'd0);
      req_valid = 4'b0010;
      rsp_ready = 1'b1;
      for (int n = 0; n < 300; n++) begin
         wait_grant(4'b0010, "stat_grant");
         @(negedge clk);
         @(negedge clk);
         drive_alu_done();
         @(negedge clk);
         alu_done = 1'b0;
         @(negedge clk);
      end
      req_valid = '0;
      rsp_ready = 1'b0;
      check("stat_grants_sat", stat_grants, 32'h0000_FF00);
      check("stat_timeouts_none", 32'(stat_timeouts), 32'd0);
`endif

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
